// File: rtl/banked_mem.sv
// rtl/banked_mem.sv - multi-bank simple-dual-port memory with write-first reads and bulk clear
module banked_mem #(
    parameter  int NUM_BANKS = 257,
    parameter  int DEPTH     = 256,
    parameter  int DATA_W    = 32,
    parameter  int RD_LAT    = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_BANKS-1:0]        we,
    input  logic [NUM_BANKS*AW-1:0]     waddr,
    input  logic [NUM_BANKS*DATA_W-1:0] wdata,
    input  logic [NUM_BANKS-1:0]        re,
    input  logic [NUM_BANKS*AW-1:0]     raddr,
    output logic [NUM_BANKS*DATA_W-1:0] rdata,
    output logic [NUM_BANKS-1:0]        rvalid,
    input  logic                        clear_start,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic                        wr_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            clear_wr;

    // Clear FSM state and sweep counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: one address per cycle, then a single DONE cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign clear_busy = (state != IDLE);
    assign clear_done = (state == DONE);
    assign clear_wr   = (state == CLEAR);

    // Flag external writes that were swallowed because a clear owns the write ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= clear_busy & (|we);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     ra;
        logic              wen;
        logic [AW-1:0]     wa_eff;
        logic [DATA_W-1:0] wd_eff;
        logic [DATA_W-1:0] rd_q;
        logic              rv_q;

        assign ra     = raddr[b*AW +: AW];
        assign wen    = clear_wr | (we[b] & ~clear_busy);
        assign wa_eff = clear_wr ? cnt : waddr[b*AW +: AW];
        assign wd_eff = clear_wr ? '0 : wdata[b*DATA_W +: DATA_W];

        // RAM array: contents deliberately not reset
        always_ff @(posedge clk) begin
            if (wen) begin
                mem[wa_eff] <= wd_eff;
            end
        end

        // First read stage with write-first bypass; data held when no read issued
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= re[b];
                if (re[b]) begin
                    rd_q <= (wen && (wa_eff == ra)) ? wd_eff : mem[ra];
                end
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_q2;
            logic              rv_q2;

            // Optional output register stage, also holding data while invalid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q2 <= '0;
                    rv_q2 <= 1'b0;
                end else begin
                    rv_q2 <= rv_q;
                    if (rv_q) begin
                        rd_q2 <= rd_q;
                    end
                end
            end

            assign rdata[b*DATA_W +: DATA_W] = rd_q2;
            assign rvalid[b]                 = rv_q2;
        end else begin : g_lat1
            assign rdata[b*DATA_W +: DATA_W] = rd_q;
            assign rvalid[b]                 = rv_q;
        end
    end

endmodule

// File: doc/banked_mem.md
# banked_mem

Parametrised multi-bank simple-dual-port memory for the NTT datapath, one independent bank per butterfly lane, with a write port and a read port per bank. It generalises the fixed 257 × 256 × 32-bit bank array: bank count, depth, data width and read latency are parameters, and the RAM is inferred rather than vendor IP. It adds per-bank read-valid tracking, same-cycle write-first forwarding, and a hardware bulk-clear engine that zeroes every bank between transforms.

## Interface
- NUM_BANKS, 257, number of independent banks (≥1)
- DEPTH, 256, words per bank (power of two, ≥2); AW = $clog2(DEPTH)
- DATA_W, 32, word width in bits
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)

- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- we  in  NUM_BANKS  per-bank write enable
- waddr  in  NUM_BANKS×AW  per-bank write address
- wdata  in  NUM_BANKS×DATA_W  per-bank write data
- re  in  NUM_BANKS  per-bank read enable
- raddr  in  NUM_BANKS×AW  per-bank read address
- rdata  out  NUM_BANKS×DATA_W  per-bank read data
- rvalid  out  NUM_BANKS  per-bank read-data valid
- clear_start  in  1  request bulk clear (one-cycle pulse, sampled in IDLE only)
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when the sweep completes
- wr_drop  out  1  pulse: at least one external write was discarded this cycle

## Operation
- Each bank i: write port (we[i], waddr[i], wdata[i]); read port (re[i], raddr[i]).
- Banks are fully independent. No cross-bank conflicts exist.
- Write-first: if re[i] and an effective write to bank i hit the same address in the same cycle, rdata[i] returns the newly written word.
- Writes in later cycles never alter an already-issued read.
- rdata[i] holds its last value while rvalid[i] is low.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_start=1 → CLEAR. The AW-bit sweep counter loads 0.
  - CLEAR: each cycle writes 0 at address counter into every bank.
    - Counter == DEPTH-1 → DONE; otherwise counter+1.
    - Sweep takes exactly DEPTH cycles.
  - DONE: clear_done=1 for one cycle → IDLE.
- clear_busy=1 in CLEAR and DONE.
- During clear_busy:
  - All external writes are discarded. wr_drop=1 in any cycle where |we is 1.
  - clear_start is ignored.
  - Reads are still served, with write-first against the clear write.
  - A read of an address not yet swept returns the old contents.
- Reset:
  - rdata=0, rvalid=0, clear_busy=0, clear_done=0, wr_drop=0; FSM=IDLE; counter=0.
  - RAM contents are not reset.
  - Reset during CLEAR aborts the sweep. Contents at unswept addresses are stale and must be treated as undefined.

## Timing
- Write: memory is updated at the clk edge where we[i]=1 (effective only when clear_busy=0).
- Read: request at edge k → rdata[i]/rvalid[i] valid after edge k+RD_LAT.
  - rvalid[i] = re[i] delayed by RD_LAT cycles.
  - Back-to-back reads give one word per cycle.
- clear_start sampled at edge k in IDLE:
  - clear_busy=1 from k+1 through k+DEPTH+1.
  - clear_done=1 in the cycle after edge k+DEPTH; it falls with clear_busy.
  - A new clear_start is accepted at edge k+DEPTH+2 at the earliest.
- wr_drop is combinational from we and clear_busy and is registered at the same edge the write would have taken effect. It is visible for the cycle after the dropped write.
- No combinational path from any input to rdata or rvalid.

## Test plan
- Fill, then read (NUM_BANKS=4, DEPTH=16, RD_LAT=1 and 2):
  - Write word 0x1000·bank+addr to all addresses, then read all.
  - Required: each word matches; rvalid is high exactly RD_LAT cycles after re.
- Write-first forwarding:
  - Bank 2 addr 5 holds 0xAAAA; same cycle we=re=1, addr 5, wdata 0x5555.
  - Required: rdata[2]=0x5555. A read of addr 5 issued the cycle before that write returns 0xAAAA.
- Bulk clear (DEPTH=16):
  - Preload nonzero, pulse clear_start.
  - Required: clear_busy high 17 cycles; clear_done pulses once 16 cycles after start; every address in every bank reads 0 afterward.
- Writes during clear:
  - Assert we[1] with 0xDEAD at addr 3 mid-sweep.
  - Required: wr_drop pulses; addr 3 reads 0 after done.
  - A second clear_start mid-sweep produces no extra clear_done.
- Reset mid-clear:
  - Drop rst_n at sweep counter 7.
  - Required: all outputs 0 immediately. A subsequent write/read of 0x1234 works, and a fresh clear completes normally.
- Independent banks:
  - Random simultaneous we/re on all banks for 10k cycles against a reference model.
  - Required: zero mismatches; rvalid matches re delayed by RD_LAT.
